intersection_phase_scheduler: RTL and testbench
===============================================

Name: intersection_phase_scheduler

Overview:
- Sequences the signal phases of one intersection: main road, side road, and a pedestrian crossing.
- Arbitrates between two latched service requests (side-road vehicle, pedestrian) with round-robin fairness.
- Honours an emergency-preempt input that returns the intersection to main green.
- Sits above the light drivers; the MR/SR/walk outputs drive the lamp interface directly.

Parameters:
- CLK_PER_SEC, 100, clock cycles per second (prescaler terminal count).
- MAIN_MIN, 20, minimum main-green dwell in seconds.
- YELLOW_T, 3, yellow dwell in seconds, both roads.
- ALLRED_T, 1, all-red dwell in seconds.
- SIDE_MAX, 10, side-green dwell in seconds.
- WALK_T, 8, pedestrian walk dwell in seconds.
- PEDCLR_T, 4, pedestrian clearance (flashing don't-walk) dwell in seconds.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- side_det  in  1  side-road vehicle detector, level, synchronous.
- ped_btn  in  1  pedestrian push button, sampled each cycle.
- emg_req  in  1  emergency preempt, level.
- MR  out  2  main-road lamp: 00 green, 01 yellow, 10 red.
- SR  out  2  side-road lamp, same encoding.
- walk  out  1  pedestrian walk lamp.
- ped_flash  out  1  flashing don't-walk enable.
- ped_wait  out  1  pedestrian request pending (button acknowledge lamp).
- phase  out  3  current state code, for debug and the bench.

Behaviour:
- States and codes: MAIN_GREEN=0, MAIN_YELLOW=1, ALLRED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, PED_WALK=5, PED_CLEAR=6, ALLRED_2=7.
- Outputs are a Moore decode of the state register:
  - MAIN_GREEN: MR=00, SR=10.
  - MAIN_YELLOW: MR=01, SR=10.
  - SIDE_GREEN: MR=10, SR=00.
  - SIDE_YELLOW: MR=10, SR=01.
  - All other states: MR=10, SR=10.
  - walk=1 only in PED_WALK; ped_flash=1 only in PED_CLEAR.
- Reset (rst=0, asynchronous):
  - state=MAIN_GREEN, so MR=00, SR=10, walk=0, ped_flash=0, ped_wait=0, phase=0.
  - Prescaler and seconds counter cleared; side_pend=0, ped_pend=0, rr_ptr=0 (side first).
- Timer:
  - The prescaler counts 0..CLK_PER_SEC-1; the terminal count produces sec_tick.
  - The seconds counter increments on sec_tick.
  - Both counters clear on every state change.
  - "dwell N" means the state is held exactly N*CLK_PER_SEC cycles, then transitions on the next edge.
  - The seconds counter saturates at 255; all dwell parameters are ≤255.
- Request latches:
  - side_pend is set by side_det=1 and cleared on the cycle SIDE_GREEN is entered.
  - ped_pend is set by ped_btn=1 and cleared on the cycle PED_WALK is entered.
  - Set and clear in the same cycle: clear wins.
  - ped_wait = ped_pend.
- Transitions:
  - MAIN_GREEN → MAIN_YELLOW when elapsed ≥ MAIN_MIN AND (side_pend|ped_pend) AND emg_req=0. With no request, main green holds indefinitely.
  - MAIN_YELLOW → ALLRED_1 after YELLOW_T.
  - ALLRED_1, after ALLRED_T, chooses the next state in this order:
    - emg_req=1 → MAIN_GREEN; pendings are retained.
    - Both requests pending → rr_ptr=0 selects SIDE_GREEN, rr_ptr=1 selects PED_WALK.
    - Only one pending → that one.
    - None pending → MAIN_GREEN.
  - rr_ptr updates when a phase is granted: 1 after a side grant, 0 after a ped grant.
  - SIDE_GREEN → SIDE_YELLOW after SIDE_MAX, or on the next edge after emg_req=1.
  - SIDE_YELLOW → ALLRED_2 after YELLOW_T.
  - PED_WALK → PED_CLEAR after WALK_T, or on the next edge after emg_req=1. The clearance interval is never skipped.
  - PED_CLEAR → ALLRED_2 after PEDCLR_T.
  - ALLRED_2 → MAIN_GREEN after ALLRED_T.
- Safety invariant: MR and SR are never both non-red; walk=1 implies MR=SR=10.
- Inputs are synchronous; metastability synchronisers sit outside this block.

Decomposition:
- Package tl_pkg holds:
  - Lamp encoding constants LAMP_GREEN/LAMP_YELLOW/LAMP_RED.
  - State enum phase_t with the codes above.
- Sub-module tl_sec_timer: prescaler plus saturating seconds counter.
  - Inputs: clk, rst, clr.
  - Output: secs[7:0].
  - Parameter: CLK_PER_SEC.
- FSM, request latches and arbiter stay in the top module.

Test Plan (CLK_PER_SEC=10):
- Reset then idle 1000 cycles with no inputs → MR=00, SR=10 throughout, phase=0.
- side_det pulse at cycle 5 → ped_wait=0; MAIN_YELLOW at cycle 200; ALLRED_1 at 230; SIDE_GREEN at 240 for 100 cycles; SIDE_YELLOW 30 cycles; ALLRED_2 10 cycles; MAIN_GREEN at 380.
- ped_btn and side_det in the same cycle after reset → ped_wait=1; side served first (rr_ptr=0); after return to main green plus MAIN_MIN, PED_WALK (walk=1, 80 cycles), then ped_flash=1 for 40 cycles; ped_wait clears on PED_WALK entry.
- emg_req asserted 30 cycles into SIDE_GREEN → SIDE_YELLOW on the next edge; after ALLRED_2, MAIN_GREEN; held there while emg_req=1 even with a pending request.
- emg_req during PED_WALK → PED_CLEAR next edge with full 40-cycle flash; ped_btn pressed on the PED_WALK entry cycle → ped_wait stays 0.
- rst driven low mid-SIDE_YELLOW, asynchronously between edges → outputs immediately MR=00, SR=10, ped_wait=0; the assertion checker confirms the safety invariant across all scenarios.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared lamp encodings and phase codes for the intersection scheduler.
package tl_pkg;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_1    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    PED_WALK    = 3'd5,
    PED_CLEAR   = 3'd6,
    ALLRED_2    = 3'd7
  } phase_t;

endpackage

// File: rtl/tl_sec_timer.sv
// Dwell timer: prescaler to one-second ticks plus a saturating seconds count.
// secs already includes the second that completes in the current cycle, so a
// compare of secs >= N fires on the last cycle of an N-second dwell and the
// state is held exactly N*CLK_PER_SEC cycles.
module tl_sec_timer #(
  parameter int CLK_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic [7:0] secs
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  logic [PW-1:0] presc;
  logic [7:0]    sec_cnt;
  logic          sec_tick;

  assign sec_tick = (presc == PW'(CLK_PER_SEC - 1));

  // prescaler and seconds counter, both restarted on every phase change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc   <= '0;
      sec_cnt <= '0;
    end else if (clr) begin
      presc   <= '0;
      sec_cnt <= '0;
    end else if (sec_tick) begin
      presc <= '0;
      if (sec_cnt != 8'hFF) sec_cnt <= sec_cnt + 8'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign secs = (sec_tick && (sec_cnt != 8'hFF)) ? sec_cnt + 8'd1 : sec_cnt;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Phase sequencer for one intersection: main road, side road, pedestrian
// crossing, with latched requests, round-robin arbitration and preempt.
//
// state       | meaning
// MAIN_GREEN  | main road green, waits for a request after minimum dwell
// MAIN_YELLOW | main road yellow
// ALLRED_1    | all red, arbitration point
// SIDE_GREEN  | side road green
// SIDE_YELLOW | side road yellow
// PED_WALK    | walk lamp on
// PED_CLEAR   | flashing don't-walk, never skipped
// ALLRED_2    | all red before returning to main green
module intersection_phase_scheduler #(
  parameter int CLK_PER_SEC = 100,
  parameter int MAIN_MIN    = 20,
  parameter int YELLOW_T    = 3,
  parameter int ALLRED_T    = 1,
  parameter int SIDE_MAX    = 10,
  parameter int WALK_T      = 8,
  parameter int PEDCLR_T    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_det,
  input  logic       ped_btn,
  input  logic       emg_req,
  output logic [1:0] MR,
  output logic [1:0] SR,
  output logic       walk,
  output logic       ped_flash,
  output logic       ped_wait,
  output logic [2:0] phase
);

  import tl_pkg::*;

  localparam logic [7:0] MAIN_MIN_S = 8'(MAIN_MIN);
  localparam logic [7:0] YELLOW_S   = 8'(YELLOW_T);
  localparam logic [7:0] ALLRED_S   = 8'(ALLRED_T);
  localparam logic [7:0] SIDE_S     = 8'(SIDE_MAX);
  localparam logic [7:0] WALK_S     = 8'(WALK_T);
  localparam logic [7:0] PEDCLR_S   = 8'(PEDCLR_T);

  phase_t     state, state_nxt;
  logic       side_pend, ped_pend, rr_ptr;
  logic       enter_side, enter_ped, clr;
  logic [7:0] secs;

  assign clr        = (state_nxt != state);
  assign enter_side = (state_nxt == SIDE_GREEN) && (state != SIDE_GREEN);
  assign enter_ped  = (state_nxt == PED_WALK) && (state != PED_WALK);

  tl_sec_timer #(.CLK_PER_SEC(CLK_PER_SEC)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .secs (secs)
  );

  // next-phase selection including arbitration and emergency preempt
  always_comb begin
    state_nxt = state;
    case (state)
      MAIN_GREEN:
        if ((secs >= MAIN_MIN_S) && (side_pend || ped_pend) && !emg_req)
          state_nxt = MAIN_YELLOW;
      MAIN_YELLOW:
        if (secs >= YELLOW_S) state_nxt = ALLRED_1;
      ALLRED_1:
        if (secs >= ALLRED_S) begin
          if (emg_req)                   state_nxt = MAIN_GREEN;
          else if (side_pend && ped_pend) state_nxt = rr_ptr ? PED_WALK : SIDE_GREEN;
          else if (side_pend)            state_nxt = SIDE_GREEN;
          else if (ped_pend)             state_nxt = PED_WALK;
          else                           state_nxt = MAIN_GREEN;
        end
      SIDE_GREEN:
        if (emg_req || (secs >= SIDE_S)) state_nxt = SIDE_YELLOW;
      SIDE_YELLOW:
        if (secs >= YELLOW_S) state_nxt = ALLRED_2;
      PED_WALK:
        if (emg_req || (secs >= WALK_S)) state_nxt = PED_CLEAR;
      PED_CLEAR:
        if (secs >= PEDCLR_S) state_nxt = ALLRED_2;
      ALLRED_2:
        if (secs >= ALLRED_S) state_nxt = MAIN_GREEN;
      default:
        state_nxt = MAIN_GREEN;
    endcase
  end

  // state register, request latches (clear wins over set) and fairness pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= MAIN_GREEN;
      side_pend <= 1'b0;
      ped_pend  <= 1'b0;
      rr_ptr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (enter_side)    side_pend <= 1'b0;
      else if (side_det) side_pend <= 1'b1;
      if (enter_ped)     ped_pend  <= 1'b0;
      else if (ped_btn)  ped_pend  <= 1'b1;
      if (enter_side)     rr_ptr <= 1'b1;
      else if (enter_ped) rr_ptr <= 1'b0;
    end
  end

  // Moore lamp decode; every state not listed shows red on both roads
  always_comb begin
    MR = LAMP_RED;
    SR = LAMP_RED;
    case (state)
      MAIN_GREEN:  MR = LAMP_GREEN;
      MAIN_YELLOW: MR = LAMP_YELLOW;
      SIDE_GREEN:  SR = LAMP_GREEN;
      SIDE_YELLOW: SR = LAMP_YELLOW;
      default:     ;
    endcase
  end

  assign walk      = (state == PED_WALK);
  assign ped_flash = (state == PED_CLEAR);
  assign ped_wait  = ped_pend;
  assign phase     = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with CLK_PER_SEC=10.
// Expected phase changes (code and cycle) are queued as stimulus is driven and
// popped by a monitor whenever the DUT phase changes; lamps are checked every
// cycle against a decode of the expected phase.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_det = 1'b0, ped_btn = 1'b0, emg_req = 1'b0;
  logic [1:0] MR, SR;
  logic       walk, ped_flash, ped_wait;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {int ph; int at;} exp_t;
  exp_t exp_q[$];
  int   mphase = 0;

  intersection_phase_scheduler #(.CLK_PER_SEC(10)) dut (
    .clk(clk), .rst(rst), .side_det(side_det), .ped_btn(ped_btn),
    .emg_req(emg_req), .MR(MR), .SR(SR), .walk(walk),
    .ped_flash(ped_flash), .ped_wait(ped_wait), .phase(phase)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] mr_of(input int ph);
    case (ph)
      0: mr_of = 2'b00;
      1: mr_of = 2'b01;
      default: mr_of = 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] sr_of(input int ph);
    case (ph)
      3: sr_of = 2'b00;
      4: sr_of = 2'b01;
      default: sr_of = 2'b10;
    endcase
  endfunction

  task automatic expect_ph(input int ph, input int at);
    exp_t e;
    e.ph = ph;
    e.at = at;
    exp_q.push_back(e);
  endtask

  // scoreboard monitor plus per-cycle lamp and safety checks
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      mphase = 0;
    end else begin
      if (32'(phase) !== 32'(mphase)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_phase", 32'(phase), 32'(mphase));
          mphase = int'(phase);
        end else begin
          e = exp_q.pop_front();
          chk("phase", 32'(phase), 32'(e.ph));
          chk("phase_cycle", 32'(cyc), 32'(e.at));
          mphase = e.ph;
        end
      end
      chk("MR", 32'(MR), 32'(mr_of(mphase)));
      chk("SR", 32'(SR), 32'(sr_of(mphase)));
      chk("walk", 32'(walk), 32'(mphase == 5));
      chk("ped_flash", 32'(ped_flash), 32'(mphase == 6));
      chk("safety", 32'(!((MR != 2'b10) && (SR != 2'b10)) &&
                        (!walk || ((MR == 2'b10) && (SR == 2'b10)))), 32'd1);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain(input int limit);
    while (exp_q.size() != 0 && cyc < limit) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    side_det = 1'b0;
    ped_btn = 1'b0;
    emg_req = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst = 1'b1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_MR", 32'(MR), 32'd0);
    chk("rst_SR", 32'(SR), 32'd2);
    chk("rst_ped_wait", 32'(ped_wait), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #1;
    // idle: main green holds forever
    do_reset();
    for (int i = 100; i <= 1000; i += 100) begin
      wait_cyc(i);
      chk("idle", 32'({MR, SR, phase}), 32'({2'b00, 2'b10, 3'd0}));
    end

    // side request only
    do_reset();
    wait_cyc(4); side_det = 1'b1;
    wait_cyc(5); side_det = 1'b0;
    wait_cyc(6);
    chk("side_ped_wait", 32'(ped_wait), 32'd0);
    expect_ph(1, 200); expect_ph(2, 230); expect_ph(3, 240);
    expect_ph(4, 340); expect_ph(7, 370); expect_ph(0, 380);
    drain(420);
    wait_cyc(600);

    // both requests: side first, then pedestrian
    do_reset();
    wait_cyc(2); side_det = 1'b1; ped_btn = 1'b1;
    wait_cyc(3); side_det = 1'b0; ped_btn = 1'b0;
    wait_cyc(4);
    chk("both_ped_wait", 32'(ped_wait), 32'd1);
    expect_ph(1, 200); expect_ph(2, 230); expect_ph(3, 240);
    expect_ph(4, 340); expect_ph(7, 370); expect_ph(0, 380);
    expect_ph(1, 580); expect_ph(2, 610); expect_ph(5, 620);
    expect_ph(6, 700); expect_ph(7, 740); expect_ph(0, 750);
    wait_cyc(619);
    chk("ped_wait_before_walk", 32'(ped_wait), 32'd1);
    wait_cyc(620);
    chk("ped_wait_at_walk", 32'(ped_wait), 32'd0);
    drain(800);
    wait_cyc(900);

    // emergency during side green, hold in main green, then emergency during walk
    do_reset();
    wait_cyc(4); side_det = 1'b1;
    wait_cyc(5); side_det = 1'b0;
    expect_ph(1, 200); expect_ph(2, 230); expect_ph(3, 240);
    expect_ph(4, 271); expect_ph(7, 301); expect_ph(0, 311);
    wait_cyc(270); emg_req = 1'b1;
    wait_cyc(280); ped_btn = 1'b1;
    wait_cyc(281); ped_btn = 1'b0;
    drain(340);
    wait_cyc(561);
    chk("emg_hold_phase", 32'(phase), 32'd0);
    chk("emg_hold_ped_wait", 32'(ped_wait), 32'd1);
    emg_req = 1'b0;
    expect_ph(1, 562); expect_ph(2, 592); expect_ph(5, 602);
    expect_ph(6, 621); expect_ph(7, 661); expect_ph(0, 671);
    wait_cyc(601); ped_btn = 1'b1;
    wait_cyc(602); ped_btn = 1'b0;
    chk("entry_press_ped_wait", 32'(ped_wait), 32'd0);
    wait_cyc(610);
    chk("entry_press_ped_wait_later", 32'(ped_wait), 32'd0);
    wait_cyc(620); emg_req = 1'b1;
    wait_cyc(680); emg_req = 1'b0;
    drain(700);
    wait_cyc(760);
    chk("post_emg_phase", 32'(phase), 32'd0);

    // asynchronous reset in the middle of side yellow
    do_reset();
    wait_cyc(2); side_det = 1'b1; ped_btn = 1'b1;
    wait_cyc(3); side_det = 1'b0; ped_btn = 1'b0;
    expect_ph(1, 200); expect_ph(2, 230); expect_ph(3, 240); expect_ph(4, 340);
    drain(360);
    wait_cyc(350);
    chk("pre_rst_ped_wait", 32'(ped_wait), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_MR", 32'(MR), 32'd0);
    chk("async_SR", 32'(SR), 32'd2);
    chk("async_ped_wait", 32'(ped_wait), 32'd0);
    chk("async_phase", 32'(phase), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("final_phase", 32'(phase), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
